// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: drives one row low at a time, reads active-low columns,
// debounces whole scan frames and reports one key code per accepted press.
module keypad4x4_scan #(
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Hit count only needs to distinguish 0, 1 and "two or more".
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s >= 4'd2) ? 2'd2 : s[1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  logic [3:0]       col_sync_p0, col_sync_p1;
  logic [DIV_W-1:0] div;
  logic [1:0]       row;
  logic [1:0]       acc_cnt;
  logic [3:0]       acc_key;
  logic             prev_hit;
  logic [3:0]       prev_key;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_nxt;

  logic             row_tick, frame_end;
  logic [3:0]       row_hits;
  logic [2:0]       row_cnt;
  logic [3:0]       row_key;
  logic [1:0]       total;
  logic             res_hit;
  logic [3:0]       res_key;
  logic             same_res;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable;
  logic             match_code;
  logic             accept, release_done;

  // Stage p0/p1: two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_sync_p0 <= 4'hF;
      col_sync_p1 <= 4'hF;
    end else begin
      col_sync_p0 <= col_n;
      col_sync_p1 <= col_sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      row <= 2'd0;
    end else if (row_tick) begin
      div <= '0;
      row <= row + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    case (row)
      2'd0:    row_n = 4'b1110;
      2'd1:    row_n = 4'b1101;
      2'd2:    row_n = 4'b1011;
      default: row_n = 4'b0111;
    endcase
  end

  assign row_tick   = (div == DIV_LAST);
  assign frame_end  = row_tick && (row == 2'd3);
  assign row_hits   = ~col_sync_p1;
  assign row_cnt    = popcount4(row_hits);
  assign row_key    = {row, low_index(row_hits)};
  assign total      = sat_add2(acc_cnt, row_cnt);
  assign res_hit    = (total == 2'd1);
  assign res_key    = (acc_cnt == 2'd1) ? acc_key : row_key;
  assign same_res   = (res_hit == prev_hit) && (!res_hit || (res_key == prev_key));
  assign cnt_nxt    = same_res ? sat_inc(cnt) : CNT_W'(1);
  assign stable     = (cnt_nxt == CNT_MAX);
  assign match_code = res_hit && (res_key == key_code);

  // Frame accumulator: rows 0..2 collect here, row 3 is folded in combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 2'd0;
      acc_key <= 4'd0;
    end else if (frame_end) begin
      acc_cnt <= 2'd0;
      acc_key <= 4'd0;
    end else if (row_tick) begin
      acc_cnt <= total;
      if (acc_cnt == 2'd0 && row_cnt == 3'd1)
        acc_key <= row_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_hit <= 1'b0;
      prev_key <= 4'd0;
      cnt      <= '0;
    end else if (frame_end) begin
      prev_hit <= res_hit;
      prev_key <= res_key;
      cnt      <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    release_done = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: if (res_hit) state_nxt = PRESS;
        PRESS: begin
          if (!res_hit) begin
            state_nxt = IDLE;
          end else if (stable) begin
            state_nxt = HELD;
            accept    = 1'b1;
          end
        end
        HELD: if (!match_code) state_nxt = RELEASE;
        RELEASE: begin
          if (match_code) begin
            state_nxt = HELD;
          end else if (!res_hit && stable) begin
            state_nxt    = IDLE;
            release_done = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept)
        key_code <= res_key;
      if (accept)
        key_down <= 1'b1;
      else if (release_done)
        key_down <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Bench for keypad4x4_scan: directed and random key activity against a frame-level
// reference model of the scanner, with a combinational keypad matrix model.
module tb_keypad4x4_scan;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int M_IDLE = 0, M_PRESS = 1, M_HELD = 2, M_RELEASE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n, row_n, key_code;
  logic        key_valid, key_down;
  logic [15:0] pressed;

  int total, passed, nfail, valid_seen, lat;

  int          m_n, m_mode;
  logic [15:0] m_d1, m_d2, m_frame;
  int          m_res_q[$];
  logic        m_valid, m_down;
  logic [3:0]  m_code;

  always #5 clk = ~clk;

  keypad4x4_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  // Keypad matrix: a pressed key shorts its column to its row while that row is driven low
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int run_len();
    int n, last;
    n = 0;
    last = m_res_q[m_res_q.size()-1];
    for (int i = m_res_q.size() - 1; i >= 0 && n < DEB; i--) begin
      if (m_res_q[i] != last) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_n = 0; m_mode = M_IDLE;
    m_d1 = '0; m_d2 = '0; m_frame = '0;
    m_res_q.delete();
    m_valid = 1'b0; m_down = 1'b0; m_code = 4'd0;
  endtask

  // One clock edge of the reference: the column read at the end of a row's dwell
  // reflects the keypad two edges earlier; each frame yields one key index or -1.
  task automatic model_step();
    logic [15:0] seen;
    int div, r, res, hits;
    bit stable;
    seen = m_d2; m_d2 = m_d1; m_d1 = pressed;
    div = m_n % SCAN_DIV;
    r = (m_n / SCAN_DIV) % 4;
    m_valid = 1'b0;
    if (div == SCAN_DIV - 1) begin
      for (int c = 0; c < 4; c++) m_frame[r*4+c] = seen[r*4+c];
      if (r == 3) begin
        hits = $countones(m_frame);
        res = -1;
        if (hits == 1)
          for (int k = 0; k < 16; k++) if (m_frame[k]) res = k;
        m_res_q.push_back(res);
        stable = (run_len() >= DEB);
        case (m_mode)
          M_IDLE: if (res >= 0) m_mode = M_PRESS;
          M_PRESS: begin
            if (res < 0) m_mode = M_IDLE;
            else if (stable) begin
              m_mode = M_HELD; m_valid = 1'b1; m_code = 4'(res); m_down = 1'b1;
            end
          end
          M_HELD: if (res != int'(m_code)) m_mode = M_RELEASE;
          default: begin
            if (res == int'(m_code)) m_mode = M_HELD;
            else if (res < 0 && stable) begin
              m_mode = M_IDLE; m_down = 1'b0;
            end
          end
        endcase
        m_frame = '0;
      end
    end
    m_n++;
  endtask

  task automatic cyc();
    logic [3:0] er;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    er = 4'hF;
    er[(m_n / SCAN_DIV) % 4] = 1'b0;
    check("row_n", {28'd0, row_n}, {28'd0, er});
    check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
    check("key_down", {31'd0, key_down}, {31'd0, m_down});
    check("key_code", {28'd0, key_code}, {28'd0, m_code});
    if (key_valid) valid_seen++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic align();
    for (int i = 0; i < FRAME && (m_n % FRAME) != 0; i++) cyc();
  endtask

  task automatic wait_valid(input int limit, output int l);
    l = -1;
    for (int i = 1; i <= limit && l < 0; i++) begin
      cyc();
      if (key_valid) l = i;
    end
  endtask

  initial begin
    int sel, a, b;
    total = 0; passed = 0; nfail = 0; valid_seen = 0;
    rst_n = 1'b0;
    pressed = '0;
    model_reset();
    run(3);
    rst_n = 1'b1;

    // Idle scanning
    run(2 * FRAME);
    check("t1_no_valid", valid_seen, 0);

    // Steady press of (2,1)
    align();
    pressed[9] = 1'b1;
    valid_seen = 0;
    wait_valid(120, lat);
    check("t2_latency", lat, 96);
    check("t2_code", {28'd0, key_code}, 32'd9);
    check("t2_down", {31'd0, key_down}, 32'd1);
    run(2 * FRAME);
    check("t2_single_valid", valid_seen, 1);

    // Release of (2,1)
    align();
    pressed = '0;
    valid_seen = 0;
    run(95);
    check("t3_down_still", {31'd0, key_down}, 32'd1);
    run(1);
    check("t3_down_fell", {31'd0, key_down}, 32'd0);
    check("t3_code_kept", {28'd0, key_code}, 32'd9);
    check("t3_no_valid", valid_seen, 0);

    // Bouncing (0,3) then hold
    valid_seen = 0;
    for (int i = 0; i < 10; i++) begin
      pressed[3] = ~pressed[3];
      run(20);
    end
    pressed[3] = 1'b1;
    run(5 * FRAME);
    check("t4_single_valid", valid_seen, 1);
    check("t4_code", {28'd0, key_code}, 32'd3);
    pressed = '0;
    run(5 * FRAME);
    check("t4_released", {31'd0, key_down}, 32'd0);

    // Ghosting: (1,0)+(1,2), then lift (1,2)
    align();
    pressed = 16'h0050;
    valid_seen = 0;
    run(5 * FRAME);
    check("t5_ghost_no_valid", valid_seen, 0);
    align();
    pressed[6] = 1'b0;
    wait_valid(120, lat);
    check("t5_latency", lat, 96);
    check("t5_code", {28'd0, key_code}, 32'd4);
    pressed = '0;
    run(5 * FRAME);

    // Reset in the middle of a debounce
    align();
    pressed[14] = 1'b1;
    run(FRAME + 13);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_row", {28'd0, row_n}, 32'he);
    check("t6_rst_valid", {31'd0, key_valid}, 32'd0);
    check("t6_rst_down", {31'd0, key_down}, 32'd0);
    check("t6_rst_code", {28'd0, key_code}, 32'd0);
    run(3);
    rst_n = 1'b1;
    wait_valid(120, lat);
    check("t6_fresh_latency", lat, 96);
    check("t6_code", {28'd0, key_code}, 32'd14);

    // Random key activity
    pressed = '0;
    run(5 * FRAME);
    for (int s = 0; s < 25; s++) begin
      sel = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (sel)
        0:       pressed = '0;
        3:       pressed = (16'd1 << a) | (16'd1 << b);
        default: pressed = 16'd1 << a;
      endcase
      run($urandom_range(20, 160));
    end
    pressed = '0;
    run(5 * FRAME);
    check("t7_idle_at_end", {31'd0, key_down}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
